// File: rtl/sincronizador_param.sv
// Parametrised button conditioner: per channel an N-flop synchroniser, a counter
// debouncer, registered press/release pulses and optional auto-repeat while held.
module sincronizador_param #(
    parameter int N_BOTONES     = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_CYC  = 4,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic                 _clk_,
    input  logic                 _reset_,
    input  logic [N_BOTONES-1:0] botones_in,
    output logic [N_BOTONES-1:0] botones_out,
    output logic [N_BOTONES-1:0] botones_pulso,
    output logic [N_BOTONES-1:0] botones_suelta
);

    localparam int DW      = $clog2(DEBOUNCE_CYC + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] REP_DLY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_PER  = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] REP_ONE  = RW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RPT,
        ST_HOLD
    } repState_e;

    if (SYNC_STAGES < 2) begin : g_badSync
        $fatal(1, "sincronizador_param: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYC < 1) begin : g_badDeb
        $fatal(1, "sincronizador_param: DEBOUNCE_CYC must be at least 1");
    end
    if (REPEAT_DELAY < 1) begin : g_badDly
        $fatal(1, "sincronizador_param: REPEAT_DELAY must be at least 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_badPer
        $fatal(1, "sincronizador_param: REPEAT_PERIOD must be at least 1");
    end

    for (genvar i = 0; i < N_BOTONES; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DW-1:0]          debCnt_q, debCnt_d;
        logic                   level_q, level_d;
        repState_e              state_q, state_d;
        logic [RW-1:0]          repCnt_q, repCnt_d;
        logic                   pulso_q, pulso_d;
        logic                   suelta_q, suelta_d;
        logic                   syncBit, accept, pressEvt, releaseEvt;

        assign syncBit    = sync_q[SYNC_STAGES-1];
        assign accept     = (syncBit != level_q) && (debCnt_q == DEB_LAST);
        assign pressEvt   = accept && syncBit;
        assign releaseEvt = accept && !syncBit;

        // Any sample agreeing with the accepted level restarts the count, so
        // only DEBOUNCE_CYC consecutive disagreeing samples flip the level.
        always_comb begin
            debCnt_d = debCnt_q;
            level_d  = level_q;
            if (syncBit == level_q) begin
                debCnt_d = '0;
            end else if (debCnt_q == DEB_LAST) begin
                level_d  = syncBit;
                debCnt_d = '0;
            end else begin
                debCnt_d = debCnt_q + 1'b1;
            end
        end

        always_comb begin
            state_d  = state_q;
            repCnt_d = repCnt_q;
            if (releaseEvt) begin
                state_d  = ST_IDLE;
                repCnt_d = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pressEvt) begin
                            repCnt_d = REP_ONE;
                            state_d  = (REPEAT_EN != 0) ? ST_WAIT : ST_HOLD;
                        end
                    end
                    ST_WAIT: begin
                        if (repCnt_q == REP_DLY) begin
                            repCnt_d = REP_ONE;
                            state_d  = ST_RPT;
                        end else begin
                            repCnt_d = repCnt_q + 1'b1;
                        end
                    end
                    ST_RPT: begin
                        if (repCnt_q == REP_PER) begin
                            repCnt_d = REP_ONE;
                        end else begin
                            repCnt_d = repCnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end

        // A release takes priority, so press and release pulses never coincide.
        always_comb begin
            pulso_d  = 1'b0;
            suelta_d = releaseEvt;
            if (!releaseEvt) begin
                case (state_q)
                    ST_IDLE: pulso_d = pressEvt;
                    ST_WAIT: pulso_d = (repCnt_q == REP_DLY);
                    ST_RPT:  pulso_d = (repCnt_q == REP_PER);
                    default: pulso_d = 1'b0;
                endcase
            end
        end

        always_ff @(posedge _clk_ or posedge _reset_) begin
            if (_reset_) begin
                sync_q   <= '0;
                debCnt_q <= '0;
                level_q  <= 1'b0;
                state_q  <= ST_IDLE;
                repCnt_q <= '0;
                pulso_q  <= 1'b0;
                suelta_q <= 1'b0;
            end else begin
                sync_q   <= {sync_q[SYNC_STAGES-2:0], botones_in[i]};
                debCnt_q <= debCnt_d;
                level_q  <= level_d;
                state_q  <= state_d;
                repCnt_q <= repCnt_d;
                pulso_q  <= pulso_d;
                suelta_q <= suelta_d;
            end
        end

        assign botones_out[i]    = level_q;
        assign botones_pulso[i]  = pulso_q;
        assign botones_suelta[i] = suelta_q;
    end

endmodule

// File: doc/sincronizador_param.md
Name: sincronizador_param

Overview:
Parametrised successor to the fixed 5-button synchroniser. Per channel it provides:
- N-stage metastability synchroniser.
- Counter-based debouncer.
- Registered press and release pulses.
- Optional auto-repeat of the press pulse while a button is held.

It sits between the raw board push-buttons and the game-control FSMs (cursor movement and select). Each channel is fully independent.

Parameters:
N_BOTONES      5  number of button channels
SYNC_STAGES    2  synchroniser flops per channel; minimum 2
DEBOUNCE_CYC   4  consecutive differing synchronised samples required to accept a new level; minimum 1
REPEAT_EN      1  1 = auto-repeat press pulses while held; 0 = one press pulse per press
REPEAT_DELAY   8  cycles from the press pulse to the first repeat pulse; minimum 1
REPEAT_PERIOD  4  cycles between subsequent repeat pulses; minimum 1

Ports:
_clk_          input   1          system clock; all logic on the rising edge
_reset_        input   1          reset, asynchronous, active-high
botones_in     input   N_BOTONES  raw asynchronous button levels (1 = pressed)
botones_out    output  N_BOTONES  debounced level, registered
botones_pulso  output  N_BOTONES  one-cycle pulse on press, plus repeat pulses, registered
botones_suelta output  N_BOTONES  one-cycle pulse on release, registered

Behaviour:
- One clock, _clk_. Reset is asynchronous and active-high on _reset_.
- While _reset_ is high, every flop and counter is 0, and all outputs are 0 immediately, with no clock needed.
- Synchroniser: SYNC_STAGES flops per channel, reset to 0. Call the last stage sync[i].
- Debouncer, per channel:
  - deb_cnt has width clog2(DEBOUNCE_CYC+1).
  - If sync[i] == botones_out[i]: deb_cnt <= 0.
  - Else if deb_cnt == DEBOUNCE_CYC-1: botones_out[i] <= sync[i] and deb_cnt <= 0.
  - Else: deb_cnt <= deb_cnt+1.
- Latency: define edge 0 as the edge that first samples a stable raw change. botones_out[i] changes at edge SYNC_STAGES+DEBOUNCE_CYC-1 (edge 5 with defaults).
- Glitch rejection: any excursion of sync[i] shorter than DEBOUNCE_CYC cycles resets deb_cnt and never reaches the outputs.
- botones_pulso[i] is high for exactly one cycle, at the same edge botones_out[i] goes 0->1.
- botones_suelta[i] is high for exactly one cycle, at the same edge botones_out[i] goes 1->0.
- Repeat FSM, per channel; rep_cnt has width clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1):
  - IDLE (botones_out=0): on the accepted press, emit the press pulse, rep_cnt <= 1, and go to WAIT if REPEAT_EN, else HOLD.
  - WAIT: rep_cnt increments each cycle. When rep_cnt == REPEAT_DELAY: pulse, rep_cnt <= 1, go to RPT.
  - RPT: rep_cnt increments. When rep_cnt == REPEAT_PERIOD: pulse, rep_cnt <= 1.
  - HOLD: no further pulses.
  - From any state, an accepted release emits the suelta pulse, clears rep_cnt and goes to IDLE. No press pulse is emitted in the release cycle.
- Resulting pulse timing: with the press pulse at cycle P, repeats occur at P+REPEAT_DELAY+k*REPEAT_PERIOD, k >= 0, while held.
- botones_pulso and botones_suelta are never both high on the same channel in the same cycle.
- Simultaneous events across channels are handled independently. Pulses on different channels may coincide.
- Reset mid-operation:
  - Asserting _reset_ aborts any state. No suelta pulse is generated.
  - After reset deasserts, a still-held button is treated as a new press: press pulse at edge SYNC_STAGES+DEBOUNCE_CYC-1 after the first sampling edge.
- Elaboration/simulation check: violation of any parameter minimum raises a fatal error.

Test Plan:
(defaults: N=5, S=2, D=4, delay 8, period 4)
1. Reset then hold: hold _reset_=1 with botones_in=5'b11111 -> all outputs 0. Release reset and keep the inputs held -> botones_out=5'b11111 and botones_pulso=5'b11111 for one cycle, at edge 5 after the first sampling edge.
2. Glitch: botones_in[1]=1 for 3 cycles, then 0 -> botones_out, botones_pulso and botones_suelta on bit 1 stay 0 throughout.
3. Bounce: botones_in[3] toggles every 2 cycles for 12 cycles, then stays 1 -> exactly one botones_pulso[3] pulse, 5 edges after the settling edge, and no suelta pulse.
4. Auto-repeat: hold botones_in[2] for 40 cycles, press pulse at P -> botones_pulso[2] at P, P+8, P+12, P+16, ... Release -> one botones_suelta[2] pulse and no further pulses. Rerun with REPEAT_EN=0 -> only the pulse at P.
5. Simultaneous: botones_in goes 0->5'b11111 on one edge -> all five press pulses in the same cycle and repeat pulses aligned. Releasing only bit 0 -> suelta[0] only; the other channels keep repeating.
6. Async reset mid-RPT: assert _reset_ between clock edges -> all outputs 0 before the next edge, no suelta pulse. Deassert with the button held -> a fresh press pulse 5 edges later.
